// File: rtl/frame_crc_packer.sv
// Packs sample-frame words (data, tail headers, CRC-16-CCITT) and per-event trailers; output one cycle after VALID/LAST_WRD.
// Define FRM_SEQ_CHECK_EN to enable expected-SEQ checking that also drives FMT_ERR.
module frame_crc_packer #(
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter int          DATA_WORDS = 96
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID,
  input  logic        CLR_CRC,
  input  logic        LAST_WRD,
  input  logic [6:0]  SEQ,
  input  logic [6:0]  SMP,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        DOUT_VLD,
  output logic        FRM_END,
  output logic [11:0] L1A_CNT,
  output logic        FMT_ERR,
  output logic [7:0]  ERR_CNT
);
  typedef enum logic [2:0] {IDLE, DATA, TAIL, WAIT, TRLR} state_t;
  localparam logic [6:0] LP_LAST_DATA = 7'(DATA_WORDS - 1);

  state_t      r_state;
  logic [15:0] r_dout;
  logic [15:0] r_crc;
  logic        r_vld;
  logic        r_frm_end;
  logic        r_fmt_err;
  logic [11:0] r_l1a;
  logic [7:0]  r_err_cnt;

  logic [15:0] w_word;
  logic [11:0] w_trl_cnt;
  logic        w_accum;
  logic        w_seq_err;
  logic        w_fmt_err;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_comb begin
    w_word = DIN;
    if (SEQ > LP_LAST_DATA) begin
      case (SEQ)
        7'd96:   w_word = {4'hA, 5'b0, SMP};
        7'd97:   w_word = {4'hB, r_l1a};
        7'd98:   w_word = {4'hC, 4'h0, r_err_cnt};
        7'd99:   w_word = r_crc;
        default: w_word = DIN;
      endcase
    end
  end

  // A trailer requested while still in TRLR reports the count after this event's increment.
  assign w_trl_cnt = (r_state == TRLR) ? r_l1a + 12'd1 : r_l1a;
  assign w_accum   = VALID && !CLR_CRC && (SEQ <= 7'd98);

`ifdef FRM_SEQ_CHECK_EN
  logic [6:0] r_exp_seq;
  logic [6:0] w_exp_seq;

  assign w_exp_seq = (r_state == IDLE || r_state == WAIT) ? 7'd0 : r_exp_seq;
  assign w_seq_err = VALID && ((SEQ != w_exp_seq) || (r_state == TRLR) || CLR_CRC);

  // Resync to the observed SEQ so a single gap raises only one error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_exp_seq <= 7'd0;
    end else if (VALID) begin
      r_exp_seq <= SEQ + 7'd1;
    end else if (r_state == IDLE || r_state == WAIT) begin
      r_exp_seq <= 7'd0;
    end
  end
`else
  assign w_seq_err = 1'b0;
`endif

  assign w_fmt_err = (LAST_WRD && (r_state != WAIT)) || w_seq_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_dout    <= 16'h0000;
      r_crc     <= CRC_INIT;
      r_vld     <= 1'b0;
      r_frm_end <= 1'b0;
      r_fmt_err <= 1'b0;
      r_l1a     <= 12'd0;
      r_err_cnt <= 8'd0;
    end else begin
      r_vld     <= 1'b0;
      r_frm_end <= 1'b0;
      r_fmt_err <= w_fmt_err;
      if (w_fmt_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (CLR_CRC) r_crc <= CRC_INIT;
      else if (w_accum) r_crc <= crc16_step(r_crc, w_word);
      if (r_state == TRLR) r_l1a <= r_l1a + 12'd1;

      if (LAST_WRD) begin
        r_dout    <= {4'hE, w_trl_cnt};
        r_vld     <= 1'b1;
        r_frm_end <= 1'b1;
        r_state   <= TRLR;
      end else if (VALID) begin
        r_dout <= w_word;
        r_vld  <= 1'b1;
        case (r_state)
          IDLE:    if (SEQ == 7'd0) r_state <= DATA;
          DATA:    if (SEQ == LP_LAST_DATA) r_state <= TAIL;
          TAIL:    if (SEQ == 7'd99) r_state <= WAIT;
          WAIT:    if (SEQ == 7'd0) r_state <= DATA;
          default: r_state <= IDLE;
        endcase
      end else if (r_state == TRLR) begin
        r_state <= IDLE;
      end
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_VLD = r_vld;
  assign FRM_END  = r_frm_end;
  assign FMT_ERR  = r_fmt_err;
  assign L1A_CNT  = r_l1a;
  assign ERR_CNT  = r_err_cnt;
endmodule

// File: tb/tb_frame_crc_packer.sv
// Scoreboard bench for frame_crc_packer: directed frames, trailers, format errors, mid-frame reset, ERR_CNT saturation.
module tb_frame_crc_packer;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
`ifdef FRM_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        VALID = 1'b0;
  logic        CLR_CRC = 1'b0;
  logic        LAST_WRD = 1'b0;
  logic [6:0]  SEQ = 7'd0;
  logic [6:0]  SMP = 7'd0;
  logic [15:0] DIN = 16'h0000;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        FRM_END;
  logic [11:0] L1A_CNT;
  logic        FMT_ERR;
  logic [7:0]  ERR_CNT;

  frame_crc_packer #(.CRC_INIT(CRC_INIT), .DATA_WORDS(96)) dut (
    .CLK(CLK), .RST(RST), .VALID(VALID), .CLR_CRC(CLR_CRC), .LAST_WRD(LAST_WRD),
    .SEQ(SEQ), .SMP(SMP), .DIN(DIN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
    .FRM_END(FRM_END), .L1A_CNT(L1A_CNT), .FMT_ERR(FMT_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] dout;
    logic        frm_end;
    logic        fmt_err;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] m_crc = CRC_INIT;
  logic [11:0] m_l1a = 12'd0;
  logic [7:0]  m_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Shift-register form of CCITT: xor the whole word in, then clock 16 times.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (DOUT_VLD) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got DOUT %0h, required no output", DOUT);
          end else begin
            e = q.pop_front();
            chk("dout", 32'(DOUT), 32'(e.dout));
            chk("frm_end", 32'(FRM_END), 32'(e.frm_end));
            chk("fmt_err", 32'(FMT_ERR), 32'(e.fmt_err));
          end
        end else if (FRM_END || FMT_ERR) begin
          n_chk++;
          n_fail++;
          $display("FAIL stray_flag: got FRM_END %0b FMT_ERR %0b without DOUT_VLD, required 0", FRM_END, FMT_ERR);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      VALID = 1'b0; CLR_CRC = 1'b0; LAST_WRD = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge CLK);
    VALID = 1'b0; CLR_CRC = 1'b1; LAST_WRD = 1'b0;
    m_crc = CRC_INIT;
  endtask

  task automatic do_valid(input logic [6:0] seq, input logic [15:0] din, input logic [6:0] smp,
                          input logic clr, input logic exp_err);
    logic [15:0] w;
    exp_t        e;
    @(negedge CLK);
    VALID = 1'b1; SEQ = seq; DIN = din; SMP = smp; CLR_CRC = clr; LAST_WRD = 1'b0;
    case (seq)
      7'd96:   w = {4'hA, 5'b0, smp};
      7'd97:   w = {4'hB, m_l1a};
      7'd98:   w = {4'hC, 4'h0, m_err};
      7'd99:   w = m_crc;
      default: w = din;
    endcase
    e = {w, 1'b0, exp_err};
    q.push_back(e);
    if (exp_err && m_err != 8'hFF) m_err = m_err + 8'd1;
    if (clr) m_crc = CRC_INIT;
    else if (seq <= 7'd98) m_crc = crc_upd(m_crc, w);
  endtask

  task automatic do_last(input logic exp_err);
    exp_t e;
    @(negedge CLK);
    VALID = 1'b0; CLR_CRC = 1'b0; LAST_WRD = 1'b1;
    e = {{4'hE, m_l1a}, 1'b1, exp_err};
    q.push_back(e);
    if (exp_err && m_err != 8'hFF) m_err = m_err + 8'd1;
    @(negedge CLK);
    LAST_WRD = 1'b0;
    m_l1a = m_l1a + 12'd1;
  endtask

  // One sample frame; 'skip' drops that SEQ, 'clr0' puts CLR_CRC on the SEQ 0 word.
  task automatic do_sample(input logic [6:0] smp, input logic [15:0] seed, input int skip, input logic clr0);
    logic e_err;
    for (int s = 0; s < 100; s++) begin
      if (s != skip) begin
        e_err = CHK && ((s == 0 && clr0) || (s == skip + 1));
        do_valid(7'(s), seed + 16'(s * 257), smp, (s == 0) && clr0, e_err);
      end
    end
  endtask

  initial begin : stim
    repeat (2) @(negedge CLK);
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_vld", 32'(DOUT_VLD), 32'h0);
    chk("rst_frm_end", 32'(FRM_END), 32'h0);
    chk("rst_fmt_err", 32'(FMT_ERR), 32'h0);
    chk("rst_l1a", 32'(L1A_CNT), 32'h0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'h0);
    RST = 1'b0;

    // All-zero frame: tail words A000/B000/C000 then CRC.
    do_clr();
    for (int s = 0; s < 100; s++) do_valid(7'(s), 16'h0000, 7'd0, 1'b0, 1'b0);

    // Second sample closes event 0 -> trailer E000.
    do_clr();
    do_sample(7'd1, 16'h1234, 200, 1'b0);
    do_last(1'b0);
    idle(1);
    chk("l1a_after_evt0", 32'(L1A_CNT), 32'd1);

    // CLR_CRC coincident with SEQ 0, SEQ gap 10->12; trailer E001.
    do_sample(7'd5, 16'hBEEF, 11, 1'b1);
    do_last(1'b0);
    idle(1);
    chk("l1a_after_evt1", 32'(L1A_CNT), 32'd2);

    // LAST_WRD while in DATA.
    do_clr();
    for (int s = 0; s <= 20; s++) do_valid(7'(s), 16'hA5A5 ^ 16'(s), 7'd9, 1'b0, 1'b0);
    do_last(1'b1);
    idle(1);
    chk("err_cnt_data_last", 32'(ERR_CNT), CHK ? 32'd3 : 32'd1);

    // Reset at SEQ 50: async clear, no trailer.
    for (int s = 0; s <= 50; s++) do_valid(7'(s), 16'h5000 + 16'(s), 7'd3, 1'b0, 1'b0);
    idle(1);
    #3 RST = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(DOUT), 32'h0);
    chk("mid_rst_vld", 32'(DOUT_VLD), 32'h0);
    chk("mid_rst_l1a", 32'(L1A_CNT), 32'h0);
    chk("mid_rst_err_cnt", 32'(ERR_CNT), 32'h0);
    chk("mid_rst_queue", 32'(q.size()), 32'd0);
    m_crc = CRC_INIT; m_l1a = 12'd0; m_err = 8'd0;
    @(negedge CLK);
    RST = 1'b0;
    do_sample(7'd2, 16'h0F0F, 200, 1'b0);
    do_last(1'b0);
    idle(1);
    chk("l1a_after_rst_evt", 32'(L1A_CNT), 32'd1);

    // Repeated LAST_WRD from IDLE drives ERR_CNT into saturation.
    repeat (260) do_last(1'b1);
    idle(1);
    chk("err_cnt_sat", 32'(ERR_CNT), 32'd255);
    chk("l1a_after_sat", 32'(L1A_CNT), 32'd261);

    idle(3);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
